// File: rtl/boton_acondicionador_test.sv
// boton_acondicionador_test: synchronise and debounce the push buttons, and fold test-button bursts into one counted strobe
module boton_acondicionador_test #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WINDOW_CYC = 20,
  parameter int CNT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sleep_raw,
  input  logic       btn_awake_raw,
  input  logic       btn_feed_raw,
  input  logic       btn_play_raw,
  input  logic       btn_test_raw,
  output logic       botonSleep,
  output logic       botonAwake,
  output logic       botonFeed,
  output logic       botonPlay,
  output logic       botonTest,
  output logic [3:0] pulseTest,
  output logic       test_busy
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int WW = $clog2(WINDOW_CYC);
  localparam logic [3:0] CMAX = 4'(CNT_MAX);
  typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;
  logic [4:0] raw;
  logic [4:0] stable;
  state_t state;
  logic test_d;
  logic press;
  logic [3:0] cnt;
  logic [WW-1:0] win;
  assign raw = {btn_test_raw, btn_play_raw, btn_feed_raw, btn_awake_raw, btn_sleep_raw};
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic s1, s2, st;
    logic [DW-1:0] c;
    // two-flop synchroniser; the level flips only after DEBOUNCE_CYC consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        st <= 1'b0;
        c  <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == st) c <= '0;
        else if (c == DW'(DEBOUNCE_CYC - 1)) begin
          st <= s2;
          c  <= '0;
        end else c <= c + 1'b1;
      end
    assign stable[i] = st;
  end
  assign botonSleep = stable[0];
  assign botonAwake = stable[1];
  assign botonFeed  = stable[2];
  assign botonPlay  = stable[3];
  assign press      = stable[4] & ~test_d;
  assign test_busy  = (state != IDLE);
  // burst counter: each debounced rising edge restarts the idle window; expiry emits the count once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      test_d    <= 1'b0;
      cnt       <= '0;
      win       <= '0;
      botonTest <= 1'b0;
      pulseTest <= '0;
    end else begin
      test_d    <= stable[4];
      botonTest <= 1'b0;
      case (state)
        IDLE:
          if (press) begin
            state <= COUNT;
            cnt   <= 4'd1;
            win   <= '0;
          end
        COUNT:
          if (press) begin
            cnt <= (cnt >= CMAX) ? CMAX : cnt + 1'b1;
            win <= '0;
          end else if (win == WW'(WINDOW_CYC - 1)) begin
            state     <= EMIT;
            botonTest <= 1'b1;
            pulseTest <= cnt;
          end else win <= win + 1'b1;
        EMIT:
          if (press) begin
            state <= COUNT;
            cnt   <= 4'd1;
            win   <= '0;
          end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_boton_acondicionador_test.sv
// tb_boton_acondicionador_test: random and directed stimulus checked every cycle against an event-level model
module tb_boton_acondicionador_test;
  localparam int D = 4;
  localparam int W = 20;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rawv = '0;
  logic bs, ba, bf, bp, bt, busy;
  logic [3:0] pt;
  int total = 0;
  int bad = 0;
  int strobes = 0;
  int s0;
  int run [5];

  boton_acondicionador_test dut (
    .clk(clk), .rst(rst),
    .btn_sleep_raw(rawv[0]), .btn_awake_raw(rawv[1]), .btn_feed_raw(rawv[2]),
    .btn_play_raw(rawv[3]), .btn_test_raw(rawv[4]),
    .botonSleep(bs), .botonAwake(ba), .botonFeed(bf), .botonPlay(bp),
    .botonTest(bt), .pulseTest(pt), .test_busy(busy)
  );

  always #5 clk = ~clk;

  // model: a level is accepted once the last D synchronised samples all disagree with it;
  // a burst ends W edges after its last press unless another press lands on that edge
  bit [4:0] hist [0:D];
  bit [4:0] mst;
  bit mprev, active, mbt;
  int c, mpulse, last, n;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      mst = '0; mprev = 0; active = 0; mbt = 0;
      c = 0; mpulse = 0; last = 0; n = 0;
    end else begin
      bit pr;
      bit [4:0] flip;
      pr = mst[4] && !mprev;
      mprev = mst[4];
      flip = '1;
      for (int k = 1; k <= D; k++) flip &= hist[k] ^ mst;
      mst ^= flip;
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = rawv;
      mbt = 0;
      if (active && !pr && n == last + W) begin
        mbt = 1; mpulse = c; active = 0;
      end
      if (pr) begin
        c = active ? ((c < CMAX) ? c + 1 : CMAX) : 1;
        active = 1;
        last = n;
      end
      n++;
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    chk("botonSleep", 8'(bs), 8'(mst[0]));
    chk("botonAwake", 8'(ba), 8'(mst[1]));
    chk("botonFeed", 8'(bf), 8'(mst[2]));
    chk("botonPlay", 8'(bp), 8'(mst[3]));
    chk("botonTest", 8'(bt), 8'(mbt));
    chk("pulseTest", 8'(pt), 8'(mpulse));
    chk("test_busy", 8'(busy), 8'(active || mbt));
    if (bt === 1'b1) strobes++;
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(int on, int off);
    rawv[4] = 1'b1;
    tick(on);
    rawv[4] = 1'b0;
    tick(off);
  endtask

  task automatic wait_strobe(string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick(1);
      ok = (bt === 1'b1);
    end
    chk({nm, "_strobe_seen"}, 8'(ok), 8'd1);
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(3);
    chk("rst_test", 8'(bt), 8'd0);
    chk("rst_pulse", 8'(pt), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    rst = 1'b1;
    tick(1);
    rawv[0] = 1'b1;
    tick(5);
    chk("sleep_before6", 8'(bs), 8'd0);
    tick(1);
    chk("sleep_at6", 8'(bs), 8'd1);
    rawv[0] = 1'b0;
    tick(8);
    chk("sleep_release", 8'(bs), 8'd0);
    rawv[2] = 1'b1; tick(2);
    rawv[2] = 1'b0; tick(2);
    rawv[2] = 1'b1; tick(2);
    rawv[2] = 1'b0; tick(12);
    chk("feed_bounce", 8'(bf), 8'd0);
    s0 = strobes;
    repeat (3) press_btn(5, 5);
    tick(16);
    chk("burst_pre", 8'(bt), 8'd0);
    tick(1);
    chk("burst_strobe", 8'(bt), 8'd1);
    chk("burst_pulse", 8'(pt), 8'd3);
    chk("burst_busy", 8'(busy), 8'd1);
    tick(1);
    chk("burst_post", 8'(bt), 8'd0);
    chk("burst_hold", 8'(pt), 8'd3);
    chk("burst_idle", 8'(busy), 8'd0);
    tick(3);
    chk("burst_count", 8'(strobes - s0), 8'd1);
    s0 = strobes;
    repeat (17) press_btn(5, 5);
    wait_strobe("sat");
    chk("sat_pulse", 8'(pt), 8'd15);
    tick(3);
    chk("sat_count", 8'(strobes - s0), 8'd1);
    s0 = strobes;
    press_btn(5, 15);
    press_btn(5, 5);
    wait_strobe("edge");
    chk("edge_pulse", 8'(pt), 8'd2);
    tick(3);
    chk("edge_count", 8'(strobes - s0), 8'd1);
    s0 = strobes;
    press_btn(5, 5);
    press_btn(5, 5);
    rst = 1'b0;
    tick(2);
    chk("midrst_pulse", 8'(pt), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    rst = 1'b1;
    tick(40);
    chk("midrst_nostrobe", 8'(strobes - s0), 8'd0);
    press_btn(5, 5);
    wait_strobe("single");
    chk("single_pulse", 8'(pt), 8'd1);
    for (int b = 0; b < 5; b++) run[b] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (run[b] == 0) begin
          rawv[b] = ~rawv[b];
          run[b] = (b == 4) ? $urandom_range(30, 1) : $urandom_range(10, 1);
        end else run[b]--;
      end
      rst = ($urandom_range(1499, 0) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst = 1'b1;
    rawv = '0;
    tick(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boton_acondicionador_test.md
Name: boton_acondicionador_test

Overview:
- Input-conditioning stage directly upstream of the sleep/test control unit.
- Synchronises and debounces the raw push-button lines, then drives the unit's level button inputs.
- Converts a burst of test-button presses into one `botonTest` strobe with the press count on `pulseTest`, which the control unit uses to select a test scenario.

Parameters:
- DEBOUNCE_CYC, 4, consecutive stable synchronised cycles required to accept a new button level (≥2).
- WINDOW_CYC, 20, idle cycles after the last test press that close a burst (≥2).
- CNT_MAX, 15, saturation value of the press counter (≤15).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- btn_sleep_raw  input  1  raw sleep button, active-high, asynchronous.
- btn_awake_raw  input  1  raw awake button.
- btn_feed_raw  input  1  raw feed button.
- btn_play_raw  input  1  raw play button.
- btn_test_raw  input  1  raw test button.
- botonSleep  output  1  debounced level.
- botonAwake  output  1  debounced level.
- botonFeed  output  1  debounced level.
- botonPlay  output  1  debounced level.
- botonTest  output  1  one-cycle strobe at the end of a test burst.
- pulseTest  output  4  press count of the last completed burst; held until the next strobe.
- test_busy  output  1  high while a burst is being counted.

Behaviour:
- Reset (rst=0, asynchronous): all synchronisers, debounce counters, stable levels, FSM and counters clear.
  - All outputs are 0 while rst=0 and until inputs change after release.
- Per input, a 2-FF synchroniser feeds a debouncer:
  - If sync≠stable, the counter increments; otherwise the counter clears.
  - On the edge where the counter equals DEBOUNCE_CYC-1 and sync≠stable, stable takes sync and the counter clears.
  - A new raw level held steadily appears on the output 2+DEBOUNCE_CYC clocks after the first sampling edge.
  - Glitches shorter than DEBOUNCE_CYC synchronised cycles never reach the output.
- Level outputs botonSleep/Awake/Feed/Play are the stable levels, registered.
- Test press = rising edge of the debounced test level; it is a one-cycle internal event.
- FSM states: IDLE, COUNT, EMIT.
  - IDLE: on a press, go to COUNT with cnt=1 and win=0.
  - COUNT: on a press, cnt=min(cnt+1,CNT_MAX) and win=0. With no press and win=WINDOW_CYC-1, go to EMIT. With no press otherwise, win++.
  - Simultaneous press and window expiry in COUNT: the press wins; the window restarts and there is no EMIT.
  - EMIT: botonTest=1 for exactly this cycle and pulseTest<=cnt, registered so both are visible together.
  - EMIT exit: a press in the EMIT cycle goes to COUNT with cnt=1 and win=0; otherwise go to IDLE.
- test_busy=1 in COUNT and EMIT, 0 in IDLE.
- cnt is 4 bits and saturates at CNT_MAX with no wrap. win is sized to hold WINDOW_CYC-1.
- botonTest is never asserted two consecutive cycles.
- pulseTest changes only in the EMIT cycle or on reset.
- Reset mid-burst: no strobe is produced; pulseTest=0 and the FSM returns to IDLE.
- Held test button: counts as a single press; its release generates no event.
- Other buttons have no effect on the test FSM.

Test Plan:
- Reset → all outputs 0 after rst low. With DEBOUNCE_CYC=4, apply btn_sleep_raw=1 one cycle after release → botonSleep=1 exactly 6 clocks after the first sampling edge.
- Bounce: btn_feed_raw toggles 1/0/1/0 with 2-cycle phases, then 0 → botonFeed stays 0 throughout.
- Burst: 3 clean test presses spaced 10 cycles apart, then silence → exactly one botonTest pulse.
  - The pulse comes WINDOW_CYC=20 cycles after the third debounced edge, +1 for EMIT.
  - pulseTest=3 in that cycle and is held afterwards; test_busy is high from the first edge to the end of EMIT.
- Saturation: 17 presses within windows → single strobe with pulseTest=15.
- Boundary: a press landing on the expiry cycle (win=19) → no strobe there. The window restarts, and the final strobe reports the count including that press.
- Reset mid-burst after 2 presses → no botonTest, pulseTest=0. A subsequent single press yields a strobe with pulseTest=1.
